// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared kind encodings, stage record and helpers for the ID-stage hazard scoreboard.
// Used by pipe_hazard_scoreboard and muldiv_busy_counter.
package pipe_hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_ALU    = 2'd1,
    KIND_LOAD   = 2'd2,
    KIND_MULDIV = 2'd3
  } kind_t;

  typedef struct packed {
    logic       valid;
    kind_t      kind;
    logic [4:0] rd;
  } stage_rec_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam stage_rec_t BUBBLE = '{valid: 1'b0, kind: KIND_NONE, rd: REG_ZERO};

  // A stage only exports a tag when it will really write a register.
  function automatic logic [4:0] stage_tag(input stage_rec_t r);
    return (r.valid && r.kind != KIND_NONE) ? r.rd : REG_ZERO;
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_muldiv_busy_counter.sv
// Busy counter for multi-cycle mul/div ops held in the EX stage.
// Loaded with MULDIV_LAT-1 on issue; EX is busy while it is non-zero.
module muldiv_busy_counter
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic ex_is_muldiv,
  output logic ex_busy,
  output logic cnt_zero
);

  localparam logic [3:0] LOAD_VAL = 4'(MULDIV_LAT - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign cnt_zero = (cnt == 4'd0);
  assign ex_busy  = ex_is_muldiv & ~cnt_zero;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks EX/MEM/WB destination tags, finish qualifiers and the ID stall.
// Optional macro HAZARD_STALL_STATS_EN adds a saturating stall_cycles counter output.
module pipe_hazard_scoreboard
  import pipe_hazard_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int KIND_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [KIND_W-1:0] id_kind,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_busy,
  output logic [4:0]        ID_EX_rd,
  output logic [4:0]        EX_MEM_rd,
  output logic [4:0]        MEM_WB_rd,
  output logic              ex_ex_finish,
  output logic              mem_ex_finish,
  output logic              mem_mem_finish,
  output logic              wb_valid
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  stage_rec_t ex_q, mem_q, wb_q;
  kind_t      id_kind_e;
  logic       issue;
  logic       cnt_zero;
  logic       ex_is_muldiv;
  logic       hazard1, hazard2;

  assign id_kind_e    = kind_t'(id_kind);
  assign ex_is_muldiv = ex_q.valid & (ex_q.kind == KIND_MULDIV);

  muldiv_busy_counter #(.MULDIV_LAT(MULDIV_LAT)) u_busy (
    .clk          (clk),
    .rst          (rst),
    .load         (issue & ~ex_busy & (id_kind_e == KIND_MULDIV)),
    .ex_is_muldiv (ex_is_muldiv),
    .ex_busy      (ex_busy),
    .cnt_zero     (cnt_zero)
  );

  assign ID_EX_rd  = stage_tag(ex_q);
  assign EX_MEM_rd = stage_tag(mem_q);
  assign MEM_WB_rd = stage_tag(wb_q);

  assign ex_ex_finish   = ex_q.valid & ((ex_q.kind == KIND_ALU) |
                                        ((ex_q.kind == KIND_MULDIV) & cnt_zero));
  assign mem_ex_finish  = mem_q.valid & ((mem_q.kind == KIND_ALU) | (mem_q.kind == KIND_MULDIV));
  assign mem_mem_finish = mem_q.valid & (mem_q.kind == KIND_LOAD);
  assign wb_valid       = wb_q.valid & (wb_q.kind != KIND_NONE) & (wb_q.rd != REG_ZERO);

  // Only the EX stage can block: MEM/WB results are always forwardable.
  assign hazard1 = id_use_rs1 & (id_rs1 != REG_ZERO) &
                   (((id_rs1 == ID_EX_rd) & ~ex_ex_finish) | ex_busy);
  assign hazard2 = id_use_rs2 & (id_rs2 != REG_ZERO) &
                   (((id_rs2 == ID_EX_rd) & ~ex_ex_finish) | ex_busy);

  assign stall_id = id_valid & ~flush & (hazard1 | hazard2);
  assign issue    = id_valid & ~flush & ~stall_id;

  // A busy mul/div freezes EX and feeds bubbles into MEM while WB keeps draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      wb_q <= mem_q;
      if (ex_busy) begin
        mem_q <= BUBBLE;
      end else begin
        mem_q <= ex_q;
        if (issue) begin
          ex_q <= '{valid: 1'b1, kind: id_kind_e, rd: id_rd};
        end else begin
          ex_q <= BUBBLE;
        end
      end
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (stall_id && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Testbench for pipe_hazard_scoreboard: directed vector table plus random stimulus vs a reference model.
// Checks stall_cycles too when HAZARD_STALL_STATS_EN is defined.
module tb_pipe_hazard_scoreboard;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_kind;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2, flush;
  logic       stall_id, ex_busy;
  logic [4:0] ID_EX_rd, EX_MEM_rd, MEM_WB_rd;
  logic       ex_ex_finish, mem_ex_finish, mem_mem_finish, wb_valid;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard #(.MULDIV_LAT(LAT), .KIND_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_kind        (id_kind),
    .id_rd          (id_rd),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .flush          (flush),
    .stall_id       (stall_id),
    .ex_busy        (ex_busy),
    .ID_EX_rd       (ID_EX_rd),
    .EX_MEM_rd      (EX_MEM_rd),
    .MEM_WB_rd      (MEM_WB_rd),
    .ex_ex_finish   (ex_ex_finish),
    .mem_ex_finish  (mem_ex_finish),
    .mem_mem_finish (mem_mem_finish),
    .wb_valid       (wb_valid)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  typedef struct {
    logic       valid;
    logic [1:0] kind;
    logic [4:0] rd, rs1, rs2;
    logic       use1, use2, fl, rs;
    logic       e_stall, e_busy;
    logic [4:0] e_idex, e_exmem, e_memwb;
    logic       e_exf, e_memex, e_memmem, e_wbv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [1:0] k, input logic [4:0] rd,
                              input logic [4:0] r1, input logic u1, input logic f, input logic r,
                              input logic st, input logic bz, input logic [4:0] t0,
                              input logic [4:0] t1, input logic [4:0] t2, input logic exf,
                              input logic mex, input logic mmem, input logic wbv);
    vec_t x;
    x.valid = v; x.kind = k; x.rd = rd; x.rs1 = r1; x.rs2 = 5'd0;
    x.use1 = u1; x.use2 = 1'b0; x.fl = f; x.rs = r;
    x.e_stall = st; x.e_busy = bz; x.e_idex = t0; x.e_exmem = t1; x.e_memwb = t2;
    x.e_exf = exf; x.e_memex = mex; x.e_memmem = mmem; x.e_wbv = wbv;
    return x;
  endfunction

  function automatic vec_t idle(input logic r, input logic st, input logic bz,
                                input logic [4:0] t0, input logic [4:0] t1, input logic [4:0] t2,
                                input logic exf, input logic mex, input logic mmem, input logic wbv);
    return mk(1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, r, st, bz, t0, t1, t2, exf, mex, mmem, wbv);
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] k, input logic [4:0] rd,
                               input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                               input logic u2, input logic f, input logic r);
    id_valid = v; id_kind = k; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    id_use_rs1 = u1; id_use_rs2 = u2; flush = f; rst = r;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: pipeline as three slots plus remaining busy cycles of the EX mul/div.
  logic       m_v[3];
  logic [1:0] m_k[3];
  logic [4:0] m_rd[3];
  int         busy_left;
  int         m_stalls;

  function automatic logic [4:0] mTag(input int s);
    return (m_v[s] && m_k[s] != 2'd0) ? m_rd[s] : 5'd0;
  endfunction

  function automatic logic mBusy();
    return m_v[0] && m_k[0] == 2'd3 && busy_left > 0;
  endfunction

  function automatic logic mExf();
    return m_v[0] && (m_k[0] == 2'd1 || (m_k[0] == 2'd3 && busy_left == 0));
  endfunction

  function automatic logic mStall();
    logic h1, h2;
    h1 = id_use_rs1 && id_rs1 != 0 && ((id_rs1 == mTag(0) && !mExf()) || mBusy());
    h2 = id_use_rs2 && id_rs2 != 0 && ((id_rs2 == mTag(0) && !mExf()) || mBusy());
    return id_valid && !flush && (h1 || h2);
  endfunction

  task automatic modelStep();
    logic st, bz;
    st = mStall();
    bz = mBusy();
    if (rst) begin
      for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_k[s] = 0; m_rd[s] = 0; end
      busy_left = 0;
      m_stalls = 0;
    end else begin
      if (st) m_stalls++;
      m_v[2] = m_v[1]; m_k[2] = m_k[1]; m_rd[2] = m_rd[1];
      if (bz) begin
        m_v[1] = 0; m_k[1] = 0; m_rd[1] = 0;
        busy_left--;
      end else begin
        m_v[1] = m_v[0]; m_k[1] = m_k[0]; m_rd[1] = m_rd[0];
        if (busy_left > 0) busy_left--;
        if (id_valid && !flush && !st) begin
          m_v[0] = 1; m_k[0] = id_kind; m_rd[0] = id_rd;
          if (id_kind == 2'd3) busy_left = LAT - 1;
        end else begin
          m_v[0] = 0; m_k[0] = 0; m_rd[0] = 0;
        end
      end
    end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, ALU back-to-back forwarding
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6, 5, 1, 0, 0,  0, 0, 5, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 6, 5, 0, 1, 1, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 6, 5, 0, 1, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 6, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Load-use: one stall cycle
    tbl.push_back(mk(1, 2, 7, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8, 7, 1, 0, 0,  1, 0, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8, 7, 1, 0, 0,  0, 0, 0, 7, 0, 0, 0, 1, 0));
    tbl.push_back(idle(0, 0, 0, 8, 0, 7, 1, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 8, 0, 0, 1, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 8, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Mul/div: three busy cycles, finishes on the fourth
    tbl.push_back(mk(1, 3, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 10, 9, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 10, 9, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 10, 9, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 10, 9, 1, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 10, 9, 0, 1, 1, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 10, 9, 0, 1, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 10, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Load to x0 never stalls nor writes back
    tbl.push_back(mk(1, 2, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 11, 0, 0, 1, 0, 1, 0));
    tbl.push_back(idle(0, 0, 0, 0, 11, 0, 0, 1, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 11, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush overrides a load-use hazard
    tbl.push_back(mk(1, 2, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 12, 3, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 3, 0, 0, 0, 1, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 3, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset in the middle of a mul/div
    tbl.push_back(mk(1, 3, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 1, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 9, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].valid, tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                    tbl[i].use1, tbl[i].use2, tbl[i].fl, tbl[i].rs);
      @(negedge clk);
      checkOutput("vec_stall_id",  i, 32'(stall_id),       32'(tbl[i].e_stall));
      checkOutput("vec_ex_busy",   i, 32'(ex_busy),        32'(tbl[i].e_busy));
      checkOutput("vec_ID_EX_rd",  i, 32'(ID_EX_rd),       32'(tbl[i].e_idex));
      checkOutput("vec_EX_MEM_rd", i, 32'(EX_MEM_rd),      32'(tbl[i].e_exmem));
      checkOutput("vec_MEM_WB_rd", i, 32'(MEM_WB_rd),      32'(tbl[i].e_memwb));
      checkOutput("vec_ex_ex_fin", i, 32'(ex_ex_finish),   32'(tbl[i].e_exf));
      checkOutput("vec_mem_ex_fin",i, 32'(mem_ex_finish),  32'(tbl[i].e_memex));
      checkOutput("vec_mem_mem_fin",i, 32'(mem_mem_finish), 32'(tbl[i].e_memmem));
      checkOutput("vec_wb_valid",  i, 32'(wb_valid),       32'(tbl[i].e_wbv));
      @(posedge clk);
      #1;
    end
`ifdef HAZARD_STALL_STATS_EN
    checkOutput("stats_after_rst", 0, stall_cycles, 32'd0);
`endif

    // Random phase: pipeline is empty here, matching a freshly cleared model
    for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_k[s] = 0; m_rd[s] = 0; end
    busy_left = 0;
    m_stalls = 0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      @(negedge clk);
      checkOutput("rnd_stall_id",   c, 32'(stall_id),       32'(mStall()));
      checkOutput("rnd_ex_busy",    c, 32'(ex_busy),        32'(mBusy()));
      checkOutput("rnd_ID_EX_rd",   c, 32'(ID_EX_rd),       32'(mTag(0)));
      checkOutput("rnd_EX_MEM_rd",  c, 32'(EX_MEM_rd),      32'(mTag(1)));
      checkOutput("rnd_MEM_WB_rd",  c, 32'(MEM_WB_rd),      32'(mTag(2)));
      checkOutput("rnd_ex_ex_fin",  c, 32'(ex_ex_finish),   32'(mExf()));
      checkOutput("rnd_mem_ex_fin", c, 32'(mem_ex_finish),  32'(m_v[1] && (m_k[1] == 1 || m_k[1] == 3)));
      checkOutput("rnd_mem_mem_fin",c, 32'(mem_mem_finish), 32'(m_v[1] && m_k[1] == 2));
      checkOutput("rnd_wb_valid",   c, 32'(wb_valid),       32'(m_v[2] && m_k[2] != 0 && m_rd[2] != 0));
`ifdef HAZARD_STALL_STATS_EN
      checkOutput("rnd_stall_cycles", c, stall_cycles, 32'(m_stalls));
`endif
      @(posedge clk);
      modelStep();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
